// File: rtl/fetch_decode_execute.sv
//------------------------------------------------------------------------------
// Module      : fetch_decode_execute
// Description : Fetch/Decode/Execute front half of a single-cycle LEGv8 core.
//               PC + instruction memory, 32x64 register file (X31 = zero),
//               sign extender, main control, ALU and branch-target adder.
// Revision    : 1.0 - initial release
//
// Ports
//   clk                  core clock, rising-edge
//   reset                asynchronous active-low; clears PC and register file
//   imem_we/addr/wdata   synchronous instruction-memory load port
//   write_back           value written to Rd when reg_write=1
//   instruction, cur_pc, opcode                fetch/decode view
//   read_data1, read_data2, extended_instruction operands
//   uncondbranch .. reg_write, alu_op          control signals
//   alu_result, zero, branch_alu_result, pc_src execute results
//
// Optional feature macro: CBNZ_EN (adds CBNZ decode and inverted-zero branch)
//------------------------------------------------------------------------------
`default_nettype none

module fetch_decode_execute #(
  parameter int WORD       = 64,
  parameter int INSTR_LEN  = 32,
  parameter int IMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [INSTR_LEN-1:0]          imem_wdata,
  input  logic [WORD-1:0]               write_back,
  output logic [INSTR_LEN-1:0]          instruction,
  output logic [WORD-1:0]               cur_pc,
  output logic [10:0]                   opcode,
  output logic [WORD-1:0]               read_data1,
  output logic [WORD-1:0]               read_data2,
  output logic [WORD-1:0]               extended_instruction,
  output logic                          uncondbranch,
  output logic                          branch,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic                          mem_to_reg,
  output logic                          alu_src,
  output logic                          reg_write,
  output logic [1:0]                    alu_op,
  output logic [WORD-1:0]               alu_result,
  output logic                          zero,
  output logic [WORD-1:0]               branch_alu_result,
  output logic                          pc_src
);

  localparam int IAW = $clog2(IMEM_DEPTH);

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  typedef enum logic [1:0] {IMM_NONE, IMM_D, IMM_CB, IMM_B} imm_fmt_t;
  typedef enum logic [2:0] {FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_PASSB} alu_fn_t;

  logic [INSTR_LEN-1:0] imem [IMEM_DEPTH];
  logic [WORD-1:0]      regs [32];

  imm_fmt_t        imm_fmt;
  alu_fn_t         alu_fn;
  logic            is_rtype;
  logic            is_cbnz;
  logic [4:0]      rn, rd, rd2_addr;
  logic [WORD-1:0] alu_b;

  // ---------------- Fetch ----------------
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end

  // Word index drops the two byte-offset bits; upper PC bits wrap the index.
  assign instruction = imem[cur_pc[IAW+1:2]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_pc <= '0;
    else        cur_pc <= pc_src ? branch_alu_result : cur_pc + WORD'(4);
  end

  // ---------------- Decode ----------------
  assign opcode = instruction[31:21];
  assign rn     = instruction[9:5];
  assign rd     = instruction[4:0];

  always_comb begin
    uncondbranch = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    alu_op       = 2'b00;
    is_rtype     = 1'b0;
    is_cbnz      = 1'b0;
    imm_fmt      = IMM_NONE;
    casez (opcode)
      OP_LDUR: begin
        alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
        imm_fmt = IMM_D;
      end
      OP_STUR: begin
        alu_src = 1'b1; mem_write = 1'b1;
        imm_fmt = IMM_D;
      end
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        reg_write = 1'b1; alu_op = 2'b10; is_rtype = 1'b1;
      end
      11'b10110100???: begin
        branch = 1'b1; alu_op = 2'b01; imm_fmt = IMM_CB;
      end
`ifdef CBNZ_EN
      11'b10110101???: begin
        branch = 1'b1; alu_op = 2'b01; imm_fmt = IMM_CB; is_cbnz = 1'b1;
      end
`endif
      11'b000101?????: begin
        uncondbranch = 1'b1; imm_fmt = IMM_B;
      end
      default: ;
    endcase
  end

  // Reg2Loc: R-type reads Rm on port 2, everything else reads Rt (stores, CBZ).
  assign rd2_addr = is_rtype ? instruction[20:16] : instruction[4:0];

  assign read_data1 = (rn == 5'd31)       ? '0 : regs[rn];
  assign read_data2 = (rd2_addr == 5'd31) ? '0 : regs[rd2_addr];

  // Reads see the pre-edge contents, so a same-cycle write is visible next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_write && rd != 5'd31) begin
      regs[rd] <= write_back;
    end
  end

  always_comb begin
    extended_instruction = '0;
    case (imm_fmt)
      IMM_D:   extended_instruction = {{(WORD-9){instruction[20]}},  instruction[20:12]};
      IMM_CB:  extended_instruction = {{(WORD-19){instruction[23]}}, instruction[23:5]};
      IMM_B:   extended_instruction = {{(WORD-26){instruction[25]}}, instruction[25:0]};
      default: extended_instruction = '0;
    endcase
  end

  // ---------------- Execute ----------------
  always_comb begin
    alu_fn = FN_ADD;
    case (alu_op)
      2'b01: alu_fn = FN_PASSB;
      2'b10: begin
        case (opcode)
          OP_SUB:  alu_fn = FN_SUB;
          OP_AND:  alu_fn = FN_AND;
          OP_ORR:  alu_fn = FN_ORR;
          default: alu_fn = FN_ADD;
        endcase
      end
      default: alu_fn = FN_ADD;
    endcase
  end

  assign alu_b = alu_src ? extended_instruction : read_data2;

  always_comb begin
    alu_result = '0;
    case (alu_fn)
      FN_ADD:   alu_result = read_data1 + alu_b;
      FN_SUB:   alu_result = read_data1 - alu_b;
      FN_AND:   alu_result = read_data1 & alu_b;
      FN_ORR:   alu_result = read_data1 | alu_b;
      FN_PASSB: alu_result = alu_b;
      default:  alu_result = '0;
    endcase
  end

  assign zero              = (alu_result == '0);
  assign branch_alu_result = cur_pc + {extended_instruction[WORD-3:0], 2'b00};
  assign pc_src            = uncondbranch | (branch & (zero ^ is_cbnz));

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_execute.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_decode_execute
// Description : Directed self-checking bench for fetch_decode_execute.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_decode_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] write_back;
  logic [31:0] instruction;
  logic [63:0] cur_pc;
  logic [10:0] opcode;
  logic [63:0] read_data1, read_data2, extended_instruction;
  logic        uncondbranch, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [63:0] alu_result;
  logic        zero;
  logic [63:0] branch_alu_result;
  logic        pc_src;

  logic        wb_follow;
  logic [63:0] wb_val;
  assign write_back = wb_follow ? alu_result : wb_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_decode_execute dut (
    .clk(clk), .reset(reset),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .write_back(write_back),
    .instruction(instruction), .cur_pc(cur_pc), .opcode(opcode),
    .read_data1(read_data1), .read_data2(read_data2),
    .extended_instruction(extended_instruction),
    .uncondbranch(uncondbranch), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .reg_write(reg_write), .alu_op(alu_op),
    .alu_result(alu_result), .zero(zero),
    .branch_alu_result(branch_alu_result), .pc_src(pc_src)
  );

  // {uncondbranch, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, alu_op}
  logic [8:0] ctrl;
  assign ctrl = {uncondbranch, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, alu_op};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] data);
    imem_addr  = 6'(idx);
    imem_wdata = data;
    imem_we    = 1'b1;
    step();
    imem_we    = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'b000000, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm, input logic [4:0] rt);
    return {op, imm, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  initial begin
    reset = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
    wb_follow = 1'b0; wb_val = '0;

    // ---------- Reset, all-NOP memory ----------
    #1;
    check_eq("reset_pc", cur_pc, 64'h0);
    for (int i = 0; i < 64; i++) load(i, 32'h0);
    check_eq("pc_held_in_reset", cur_pc, 64'h0);
    reset = 1'b1;
    check_eq("nop_ctrl", 64'(ctrl), 64'h0);
    check_eq("nop_pc_src", 64'(pc_src), 64'h0);
    step();
    check_eq("nop_pc_4", cur_pc, 64'h4);
    step();
    check_eq("nop_pc_8", cur_pc, 64'h8);
    check_eq("nop_reg_write", 64'(reg_write), 64'h0);

    // ---------- Program load during reset ----------
    #2 reset = 1'b0;
    #1;
    check_eq("async_reset_pc", cur_pc, 64'h0);
    load(0, enc_d(11'b11111000010, 9'd8, 5'd0, 5'd3));          // LDUR X3,[X0,#8]
    load(1, enc_r(11'b10001011000, 5'd3, 5'd3, 5'd1));          // ADD  X1,X3,X3
    load(2, enc_r(11'b11001011000, 5'd1, 5'd1, 5'd2));          // SUB  X2,X1,X1
    load(3, enc_r(11'b10101010000, 5'd3, 5'd1, 5'd1));          // ORR  X1,X1,X3
    load(4, enc_cb(8'b10110100, 19'd3, 5'd31));                 // CBZ  X31,#3
    load(6, enc_r(11'b10001011000, 5'd3, 5'd3, 5'd31));         // ADD  X31,X3,X3
    load(7, enc_cb(8'b10110100, 19'd2, 5'd1));                  // CBZ  X1,#2
    load(8, enc_b(26'h3FFFFFE));                                // B    #-2
    reset = 1'b1;

    // PC 0x00: LDUR, write_back models a loaded value
    wb_val = 64'h1234_5678;
    check_eq("ldur_alu", alu_result, 64'h8);
    check_eq("ldur_ext", extended_instruction, 64'h8);
    check_eq("ldur_ctrl", 64'(ctrl), 64'(9'b001011100));
    step();

    // PC 0x04: ADD X1,X3,X3 (X3 written by previous edge)
    wb_follow = 1'b1;
    check_eq("add_pc", cur_pc, 64'h4);
    check_eq("add_rd1", read_data1, 64'h1234_5678);
    check_eq("add_alu", alu_result, 64'h2468_ACF0);
    check_eq("add_ctrl", 64'(ctrl), 64'(9'b000000110));
    step();

    // PC 0x08: SUB X2,X1,X1
    check_eq("sub_alu", alu_result, 64'h0);
    check_eq("sub_zero", 64'(zero), 64'h1);
    step();

    // PC 0x0C: ORR X1,X1,X3 reads old X1 while overwriting it
    check_eq("orr_alu", alu_result, 64'h367C_FEF8);
    step();

    // PC 0x10: CBZ X31,#3 -> taken to 0x1C
    check_eq("cbz_ctrl", 64'(ctrl), 64'(9'b010000001));
    check_eq("cbz_target", branch_alu_result, 64'h1C);
    check_eq("cbz_pc_src", 64'(pc_src), 64'h1);
    step();
    check_eq("cbz_next_pc", cur_pc, 64'h1C);

    // PC 0x1C: CBZ X1,#2 with X1 nonzero -> falls through
    check_eq("cbz_nz_rd2", read_data2, 64'h367C_FEF8);
    check_eq("cbz_nz_pc_src", 64'(pc_src), 64'h0);
    step();
    check_eq("cbz_nz_next_pc", cur_pc, 64'h20);

    // PC 0x20: B #-2 -> 0x18
    check_eq("b_ext", extended_instruction, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("b_ctrl", 64'(ctrl), 64'(9'b100000000));
    step();
    check_eq("b_next_pc", cur_pc, 64'h18);

    // PC 0x18: ADD X31 with write_back 0xFFFF; replace word 7 with a NOP reading X31
    wb_follow = 1'b0; wb_val = 64'hFFFF;
    check_eq("x31_write_en", 64'(reg_write), 64'h1);
    load(7, 32'h0000_03E0);
    check_eq("nop_pc_1c", cur_pc, 64'h1C);
    check_eq("x31_reads_zero", read_data1, 64'h0);
    check_eq("nop2_ctrl", 64'(ctrl), 64'h0);

    // PC 0x1C -> 0x20, placing CBNZ X1,#4 at word 8
    load(8, enc_cb(8'b10110101, 19'd4, 5'd1));
`ifdef CBNZ_EN
    check_eq("cbnz_pc_src", 64'(pc_src), 64'h1);
    step();
    check_eq("cbnz_next_pc", cur_pc, 64'h30);
`else
    check_eq("cbnz_off_ctrl", 64'(ctrl), 64'h0);
    step();
    check_eq("cbnz_off_next_pc", cur_pc, 64'h24);
`endif

    // Mid-program asynchronous reset
    wb_val = 64'hAB;
    #2 reset = 1'b0;
    #1;
    check_eq("midreset_pc", cur_pc, 64'h0);
    check_eq("midreset_x3_clear", read_data2, 64'h0);
    step();
    check_eq("reset_hold_pc", cur_pc, 64'h0);
    check_eq("reset_block_write", read_data2, 64'h0);
    reset = 1'b1;
    step();
    check_eq("restart_pc", cur_pc, 64'h4);
    check_eq("restart_x3", read_data1, 64'hAB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
